digit_grab: RTL and testbench
=============================

# digit_grab

Video-stream hex-byte reader: watches the same `hs`/`vs`/`pixel` raster that the on-screen hex overlay drives and decodes the two 8×8 hex glyphs at a fixed screen position back into an 8-bit value. It sits on the overlay's output as a self-check and test-readback block, so the OSD path can be verified in-system without a frame grabber. Recovery is by row-by-row template matching against the shared 16-glyph hex font.

## Interface
- `X`, 0: column of the window origin, in ce-cycles after the horizontal sync falling edge.
- `Y`, 0: first line of the window, in lines after the vertical sync falling edge.
- `LAT`, 2: pixel latency from `x == X` to glyph column 0 on `pixel`.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ce`  in  1  pixel clock enable; all state advances only when `ce` = 1.
- `hs`  in  1  horizontal sync, same polarity as the overlay.
- `vs`  in  1  vertical sync.
- `pixel`  in  1  overlay pixel stream.
- `value`  out  8  last decoded byte; high nibble is the left glyph.
- `valid`  out  1  one-ce-cycle pulse when `value` updates.
- `error`  out  1  one-ce-cycle pulse when a decode fails (see Configuration).

## Operation
- Sync edge detect: `hsd`/`vsd` are delayed copies of `hs`/`vs`. `xrs` = ~hs & hsd and `yrs` = ~vs & vsd, both registered.
- `x` is 10 bits: cleared on `xrs`, otherwise incremented. `y` is 10 bits: cleared on `yrs`, incremented on `xrs`. Both wrap modulo 1024.
- Window: lines `Y`..`Y+7` form glyph rows r = 0..7. Columns c = 0..15 are sampled on the ce-cycle where `x == X+LAT+c`. Columns 0–7 belong to the high glyph, 8–15 to the low glyph, MSB first.
- FSM states:
  - IDLE: on `yrs`, go to ARM, with both candidate masks `mh` and `ml` set to 16'hFFFF.
  - ARM: wait for `y == Y+r`, then go to SHIFT.
  - SHIFT: shift the 16 sampled pixels into `row`.
  - MATCH: one cycle after column 15. `mh &= match(row[15:8], r)` and `ml &= match(row[7:0], r)`. If r < 7, increment r and return to ARM. If r = 7, go to DONE.
  - DONE: if `mh` and `ml` are each one-hot, load `value` = {enc(`mh`), enc(`ml`)} and pulse `valid`. Otherwise pulse `error`. Return to IDLE.
- `match(b, r)` bit n = (b == font[{n, r}]). This is 16 parallel 8-bit comparators.
- Abort: a `yrs` while in ARM, SHIFT or MATCH restarts the frame at ARM with the masks reset. No `valid` or `error` is produced for the aborted frame.
- A window that never completes (for example Y+7 is beyond the frame) produces no output.
- `value` holds its last good result until the next `valid`.

## Timing
- Reset values: `value` = 8'h00, `valid` = 0, `error` = 0, FSM = IDLE, masks = 16'hFFFF, `x` = `y` = 0, `r` = 0.
- Capture edge: a pixel present on the ce-cycle where `x == X+LAT+c` is captured on that edge.
- Result latency: `valid`/`error` assert exactly 2 ce-cycles after column 15 of row 7 is sampled (MATCH, then DONE). They last one ce-cycle.
- Reset mid-window takes effect immediately and asynchronously. No output pulse is produced for the interrupted frame.
- `ce` = 0 freezes all state and outputs, including the pulse length.
- An `xrs` landing inside SHIFT (line too short) aborts the frame as for `yrs`.

## Configuration
- `DIGIT_GRAB_ERR_EN` defined: the failed-decode path is built and `error` pulses as described.
- Undefined: `error` is tied to 0, the one-hot check is still performed, and failed frames are dropped silently.

## Structure
- Package `digit_font_pkg` holds the 128×8 hex font constant, glyph width/height localparams (8, 8), and the FSM state enum.
- Sub-module `digit_grab_match`: combinational matcher, 8-bit row in, 3-bit row index in, 16-bit match vector out. Instantiated twice, once per glyph.
- Counters, sync edge detection and the FSM live in the top module.

## Test plan
- Ideal raster (hs period 64, vs period 20 lines, X = 10, Y = 4, LAT = 2) carrying glyphs for 0x3A → one `valid` with `value` = 8'h3A, 2 ce-cycles after the last sample; no `error`.
- Successive frames carrying 0x00, 0xFF, 0x5B → three `valid` pulses with values 00, FF, 5B; `value` holds between frames.
- Flip one pixel in row 3 of the low glyph → `error` pulses (with macro), `value` unchanged. Without the macro, no pulse.
- `vs` falling edge injected during row 5 → no output for that frame; the next clean frame decodes correctly.
- `reset_n` low during row 2, released → all outputs 0; the next full frame decodes correctly.
- `ce` toggling 1/0/0 throughout with stimulus held across gaps → same results as the `ce` = 1 case; `valid` is one ce-cycle wide.

Source files
------------

// File: rtl/digit_font_pkg.sv
// Shared 16-glyph 8x8 hex font, glyph geometry and readback FSM states.
// Row r of glyph n lives at FONT[{n, r}], MSB is the leftmost pixel.
package digit_font_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SHIFT,
    S_MATCH,
    S_DONE
  } state_t;

  localparam logic [0:127][7:0] FONT = {
    64'h3C666E7666663C00,
    64'h183818181818_7E00,
    64'h3C66060C30607E00,
    64'h3C66061C06663C00,
    64'h0C1C3C6C7E0C0C00,
    64'h7E607C0606663C00,
    64'h3C66607C66663C00,
    64'h7E660C1818181800,
    64'h3C66663C66663C00,
    64'h3C66663E06663C00,
    64'h183C667E66666600,
    64'h7C66667C66667C00,
    64'h3C66606060663C00,
    64'h786C6666666C7800,
    64'h7E60607860607E00,
    64'h7E60607860606000
  };

  function automatic logic onehot16(input logic [15:0] m);
    return (m != '0) && ((m & (m - 16'd1)) == '0);
  endfunction

  function automatic logic [3:0] enc16(input logic [15:0] m);
    logic [3:0] e;
    e = '0;
    for (int i = 0; i < 16; i++)
      if (m[i]) e = 4'(i);
    return e;
  endfunction

endpackage

// File: rtl/digit_grab_match.sv
// Row matcher: flags every glyph whose row r equals the sampled byte.
// Sixteen parallel byte comparators against the shared font.
module digit_grab_match
  import digit_font_pkg::*;
(
  input  logic [GLYPH_W-1:0]         row,
  input  logic [$clog2(GLYPH_H)-1:0] r,
  output logic [15:0]                hit
);

  for (genvar n = 0; n < 16; n++) begin : g_cmp
    assign hit[n] = (row == FONT[{4'(n), r}]);
  end

endmodule

// File: rtl/digit_grab.sv
// digit_grab: reads back the two hex glyphs drawn by the OSD overlay.
// Define DIGIT_GRAB_ERR_EN to build the failed-decode error pulse.
module digit_grab
  import digit_font_pkg::*;
#(
  parameter int X   = 0,
  parameter int Y   = 0,
  parameter int LAT = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       hs,
  input  logic       vs,
  input  logic       pixel,
  output logic [7:0] value,
  output logic       valid,
  output logic       error
);

  state_t      state, nstate;
  logic        hsd, vsd, xrs, yrs;
  logic [9:0]  x, y, x_tgt, y_tgt;
  logic [2:0]  r;
  logic [3:0]  col;
  logic [15:0] row, mh, ml;
  logic [15:0] hit_h, hit_l, mh_n, ml_n;
  logic        hit_x, take, restart;
  logic        fold, finish, ok;

  assign x_tgt = 10'(X + LAT) + 10'(col);
  assign y_tgt = 10'(Y) + 10'(r);
  assign hit_x = (x == x_tgt);

  digit_grab_match u_hi (
    .row (row[15:8]),
    .r   (r),
    .hit (hit_h)
  );

  digit_grab_match u_lo (
    .row (row[7:0]),
    .r   (r),
    .hit (hit_l)
  );

  assign mh_n = mh & hit_h;
  assign ml_n = ml & hit_l;
  assign ok   = onehot16(mh_n) && onehot16(ml_n);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hsd <= 1'b0;
      vsd <= 1'b0;
      xrs <= 1'b0;
      yrs <= 1'b0;
      x   <= '0;
      y   <= '0;
    end else if (ce) begin
      hsd <= hs;
      vsd <= vs;
      xrs <= ~hs & hsd;
      yrs <= ~vs & vsd;
      x   <= xrs ? '0 : x + 10'd1;
      if (yrs)
        y <= '0;
      else if (xrs)
        y <= y + 10'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else if (ce)
      state <= nstate;
  end

  // A new frame (or a line that ends mid-capture) always restarts at row 0.
  always_comb begin
    nstate  = state;
    take    = 1'b0;
    restart = 1'b0;
    fold    = 1'b0;
    finish  = 1'b0;
    if (yrs) begin
      nstate  = S_ARM;
      restart = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: nstate = S_IDLE;
        S_ARM: begin
          if (y == y_tgt) begin
            nstate = S_SHIFT;
            take   = hit_x;
          end
        end
        S_SHIFT: begin
          if (xrs) begin
            nstate  = S_ARM;
            restart = 1'b1;
          end else if (hit_x) begin
            take = 1'b1;
            if (col == 4'd15)
              nstate = S_MATCH;
          end
        end
        S_MATCH: begin
          fold   = 1'b1;
          finish = (r == 3'd7);
          nstate = finish ? S_DONE : S_ARM;
        end
        S_DONE:  nstate = S_IDLE;
        default: nstate = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mh  <= 16'hFFFF;
      ml  <= 16'hFFFF;
      r   <= '0;
      col <= '0;
      row <= '0;
    end else if (ce) begin
      if (restart) begin
        mh  <= 16'hFFFF;
        ml  <= 16'hFFFF;
        r   <= '0;
        col <= '0;
      end else if (take) begin
        row <= {row[14:0], pixel};
        col <= col + 4'd1;
      end else if (fold) begin
        mh  <= mh_n;
        ml  <= ml_n;
        r   <= r + 3'd1;
        col <= '0;
      end
    end
  end

  // Result registers load at the final MATCH so they show during DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
      valid <= 1'b0;
    end else if (ce) begin
      valid <= finish && ok;
      if (finish && ok)
        value <= {enc16(mh_n), enc16(ml_n)};
    end
  end

`ifdef DIGIT_GRAB_ERR_EN
  logic err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      err_q <= 1'b0;
    else if (ce)
      err_q <= finish && !ok;
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_digit_grab.sv
// Bench for digit_grab: raster generator, font-based reference decoder,
// and a scoreboard monitor checking each valid/error pulse.
module tb_digit_grab;

  localparam int XP   = 10;
  localparam int YP   = 4;
  localparam int LATP = 2;
  localparam int HLEN = 64;
  localparam int VLEN = 20;
  // first glyph column sits this many ce-cycles after hs falls
  localparam int K0   = XP + LATP + 2;

  localparam logic [63:0] GL [16] = '{
    64'h3C666E7666663C00, 64'h1838181818187E00,
    64'h3C66060C30607E00, 64'h3C66061C06663C00,
    64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00,
    64'h3C66607C66663C00, 64'h7E660C1818181800,
    64'h3C66663C66663C00, 64'h3C66663E06663C00,
    64'h183C667E66666600, 64'h7C66667C66667C00,
    64'h3C66606060663C00, 64'h786C6666666C7800,
    64'h7E60607860607E00, 64'h7E60607860606000
  };

  typedef struct {
    bit         err;
    logic [7:0] val;
    int         t;
  } exp_t;

  logic       clock, reset_n, ce;
  logic       hs, vs, pixel;
  logic [7:0] value;
  logic       valid, error;

  exp_t       q[$];
  int         checks, errors;
  int         tick_n;
  int         gap_mode;
  logic [7:0] last_good;

  digit_grab #(
    .X   (XP),
    .Y   (YP),
    .LAT (LATP)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ce      (ce),
    .hs      (hs),
    .vs      (vs),
    .pixel   (pixel),
    .value   (value),
    .valid   (valid),
    .error   (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic glyph_bit(
    input logic [7:0] v, input int r, input int c);
    logic [3:0] nib;
    nib = (c < 8) ? v[7:4] : v[3:0];
    return GL[nib][63 - 8*r - (c % 8)];
  endfunction

  // Glyph index whose whole bitmap equals the captured rows, else -1.
  function automatic int find(input logic [7:0] rows [8]);
    int  hitn, cnt;
    bit  same;
    hitn = -1;
    cnt  = 0;
    for (int n = 0; n < 16; n++) begin
      same = 1'b1;
      for (int rr = 0; rr < 8; rr++)
        if (GL[n][63-8*rr -: 8] !== rows[rr]) same = 1'b0;
      if (same) begin
        cnt++;
        hitn = n;
      end
    end
    return (cnt == 1) ? hitn : -1;
  endfunction

  task automatic chk(input string nm,
                     input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  task automatic tick(input logic h, input logic v, input logic p);
    int gaps;
    hs    = h;
    vs    = v;
    pixel = p;
    ce    = 1'b1;
    tick_n++;
    @(posedge clock); #1;
    gaps = (gap_mode == 1) ? 2 :
           (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int g = 0; g < gaps; g++) begin
      ce = 1'b0;
      @(posedge clock); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] v,
                            input int fr, input int fc,
                            input bit abort, input bit do_rst);
    logic [7:0] cap_hi [8];
    logic [7:0] cap_lo [8];
    logic       h, vv, p;
    int         r, c, hi, lo;
    for (int l = 0; l < VLEN; l++) begin
      for (int k = 0; k < HLEN; k++) begin
        h  = (k >= 4);
        vv = (l >= 2);
        p  = 1'b0;
        if (abort && l == YP + 5 && k >= 20 && k < 23)
          vv = 1'b0;
        if (do_rst && l == YP + 2 && k == 20) begin
          reset_n = 1'b0;
          #1;
          chk("rst_value", value, 8'h00);
          chk("rst_valid", {7'd0, valid}, 8'h00);
          chk("rst_error", {7'd0, error}, 8'h00);
          last_good = 8'h00;
        end
        if (do_rst && l == YP + 2 && k == 23)
          reset_n = 1'b1;
        if (l >= YP && l < YP + 8 && k >= K0 && k < K0 + 16) begin
          r = l - YP;
          c = k - K0;
          p = glyph_bit(v, r, c);
          if (r == fr && c == fc) p = ~p;
          if (c < 8) cap_hi[r][7-c] = p;
          else       cap_lo[r][15-c] = p;
          if (r == 7 && c == 15 && !abort && !do_rst) begin
            hi = find(cap_hi);
            lo = find(cap_lo);
            if (hi >= 0 && lo >= 0) begin
              last_good = {hi[3:0], lo[3:0]};
              q.push_back('{1'b0, last_good, tick_n + 3});
            end else begin
`ifdef DIGIT_GRAB_ERR_EN
              q.push_back('{1'b1, last_good, tick_n + 3});
`endif
            end
          end
        end
        tick(h, vv, p);
      end
    end
    chk("value_hold", value, last_good);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset_n && ce && (valid || error)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: valid=%0b error=%0b value=%h tick=%0d, required no pulse",
                 valid, error, value, tick_n);
      end else begin
        e = q.pop_front();
        if (valid !== !e.err || error !== e.err ||
            value !== e.val || tick_n != e.t) begin
          errors++;
          $display("FAIL pulse: got valid=%0b error=%0b value=%h tick=%0d, required valid=%0b error=%0b value=%h tick=%0d",
                   valid, error, value, tick_n,
                   !e.err, e.err, e.val, e.t);
        end
      end
    end
  end

  initial begin
    logic [7:0] rv;
    int         fr, fc;
    checks    = 0;
    errors    = 0;
    tick_n    = 0;
    gap_mode  = 0;
    last_good = 8'h00;
    reset_n   = 1'b0;
    ce        = 1'b0;
    hs        = 1'b1;
    vs        = 1'b1;
    pixel     = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("init_value", value, 8'h00);
    chk("init_valid", {7'd0, valid}, 8'h00);
    chk("init_error", {7'd0, error}, 8'h00);
    reset_n = 1'b1;
    repeat (8) tick(1'b1, 1'b1, 1'b0);

    send_frame(8'h3A, -1, -1, 0, 0);
    send_frame(8'h00, -1, -1, 0, 0);
    send_frame(8'hFF, -1, -1, 0, 0);
    send_frame(8'h5B, -1, -1, 0, 0);
    send_frame(8'h7C, 3, 8 + int'($urandom_range(0, 7)), 0, 0);
    send_frame(8'h11, -1, -1, 1, 0);
    send_frame(8'h42, -1, -1, 0, 0);
    send_frame(8'h99, -1, -1, 0, 1);
    send_frame(8'hC4, -1, -1, 0, 0);

    gap_mode = 1;
    send_frame(8'h3A, -1, -1, 0, 0);
    send_frame(8'h00, -1, -1, 0, 0);
    send_frame(8'h5B, -1, -1, 0, 0);
    send_frame(8'hE1, 3, 8 + int'($urandom_range(0, 7)), 0, 0);

    for (int i = 0; i < 6; i++) begin
      gap_mode = int'($urandom_range(0, 2));
      rv = 8'($urandom);
      fr = -1;
      fc = -1;
      if ($urandom_range(0, 3) == 0) begin
        fr = int'($urandom_range(0, 7));
        fc = int'($urandom_range(0, 15));
      end
      send_frame(rv, fr, fc, 0, 0);
    end

    gap_mode = 0;
    repeat (8) tick(1'b1, 1'b1, 1'b0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: got %0d outstanding, required 0",
               q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
